// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel mux with manual, round-robin scan and hold modes
module scan_mux #(
    parameter  int W     = 1,
    parameter  int N     = 32,
    parameter  int DWELL = 16,
    localparam int SELW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    c,
    input  logic [SELW-1:0]   sw,
    input  logic [1:0]        mode,
    input  logic              load,
    output logic [W-1:0]      o,
    output logic [SELW-1:0]   cur_sel,
    output logic              wrap
);

    localparam int DCW = $clog2(DWELL) + 1;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    logic [W-1:0]    ch [N];

    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    mode_e           mode_q, mode_d;
    logic [W-1:0]    o_q, o_d;
    logic            wrap_q, wrap_d;
    logic            sw_ok;

    // Unpack the flat channel bus so channel i can be indexed directly.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch[i] = c[i*W +: W];
    end

    // A request for a channel that does not exist (N not a power of two) is ignored.
    assign sw_ok = ({1'b0, sw} < (SELW+1)'(N));

    // Next-state: select, dwell counter, wrap pulse and output mux for each mode.
    always_comb begin
        cur_sel_d = cur_sel_q;
        dcnt_d    = dcnt_q;
        o_d       = o_q;
        wrap_d    = 1'b0;
        mode_d    = mode_e'(mode);

        case (mode_e'(mode))
            MODE_MANUAL: begin
                if (sw_ok) begin
                    cur_sel_d = sw;
                end
                dcnt_d = '0;
                o_d    = ch[cur_sel_q];
            end
            MODE_SCAN: begin
                o_d = ch[cur_sel_q];
                if (load) begin
                    // Load wins over both the entry rule and the dwell advance.
                    if (sw_ok) begin
                        cur_sel_d = sw;
                    end
                    dcnt_d = '0;
                end else if (mode_q != MODE_SCAN) begin
                    // Fresh entry: start a full dwell on the channel we are already on.
                    dcnt_d = '0;
                end else if (dcnt_q == DCW'(DWELL - 1)) begin
                    dcnt_d = '0;
                    if (cur_sel_q == SELW'(N - 1)) begin
                        cur_sel_d = '0;
                        wrap_d    = 1'b1;
                    end else begin
                        cur_sel_d = cur_sel_q + 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                // HOLD and the reserved code freeze everything.
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel_q <= '0;
            dcnt_q    <= '0;
            mode_q    <= MODE_MANUAL;
            o_q       <= '0;
            wrap_q    <= 1'b0;
        end else begin
            cur_sel_q <= cur_sel_d;
            dcnt_q    <= dcnt_d;
            mode_q    <= mode_d;
            o_q       <= o_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o       = o_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed table-driven bench for scan_mux
module tb_scan_mux;

    logic clk;
    logic rst;
    logic rst8;

    // N=32, W=1, DWELL=16
    logic [31:0] c32;
    logic [4:0]  sw32;
    logic [1:0]  mode32;
    logic        load32;
    logic        o32;
    logic [4:0]  cur32;
    logic        wrap32;

    // N=4, W=8, DWELL=3
    logic [31:0] c4;
    logic [1:0]  sw4;
    logic [1:0]  mode4;
    logic        load4;
    logic [7:0]  o4;
    logic [1:0]  cur4;
    logic        wrap4;

    // N=5, W=4, DWELL=2
    logic [19:0] c5;
    logic [2:0]  sw5;
    logic [1:0]  mode5;
    logic        load5;
    logic [3:0]  o5;
    logic [2:0]  cur5;
    logic        wrap5;

    // N=8, W=4, DWELL=1
    logic [31:0] c8;
    logic [2:0]  sw8;
    logic [1:0]  mode8;
    logic        load8;
    logic [3:0]  o8;
    logic [2:0]  cur8;
    logic        wrap8;

    int tests;
    int fails;

    scan_mux #(.W(1), .N(32), .DWELL(16)) u32 (
        .clk(clk), .rst(rst), .c(c32), .sw(sw32), .mode(mode32), .load(load32),
        .o(o32), .cur_sel(cur32), .wrap(wrap32)
    );

    scan_mux #(.W(8), .N(4), .DWELL(3)) u4 (
        .clk(clk), .rst(rst), .c(c4), .sw(sw4), .mode(mode4), .load(load4),
        .o(o4), .cur_sel(cur4), .wrap(wrap4)
    );

    scan_mux #(.W(4), .N(5), .DWELL(2)) u5 (
        .clk(clk), .rst(rst), .c(c5), .sw(sw5), .mode(mode5), .load(load5),
        .o(o5), .cur_sel(cur5), .wrap(wrap5)
    );

    scan_mux #(.W(4), .N(8), .DWELL(1)) u8 (
        .clk(clk), .rst(rst8), .c(c8), .sw(sw8), .mode(mode8), .load(load8),
        .o(o8), .cur_sel(cur8), .wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sw;
        logic [31:0] c;
        logic [4:0]  exp_sel;
        logic        exp_o;
    } vec_t;

    vec_t vt [6];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int     seq4  [13];
        logic [7:0] o4e [13];
        int     e;

        tests = 0;
        fails = 0;

        vt[0] = '{sw: 5'd31, c: 32'h8000_0001, exp_sel: 5'd31, exp_o: 1'b1};
        vt[1] = '{sw: 5'd0,  c: 32'h8000_0001, exp_sel: 5'd0,  exp_o: 1'b1};
        vt[2] = '{sw: 5'd0,  c: 32'hFFFF_FFFE, exp_sel: 5'd0,  exp_o: 1'b0};
        vt[3] = '{sw: 5'd20, c: 32'h0010_0000, exp_sel: 5'd20, exp_o: 1'b1};
        vt[4] = '{sw: 5'd21, c: 32'h0010_0000, exp_sel: 5'd21, exp_o: 1'b0};
        vt[5] = '{sw: 5'd15, c: 32'h0000_8000, exp_sel: 5'd15, exp_o: 1'b1};

        seq4 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        o4e  = '{8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hB2, 8'hB2, 8'hB2,
                 8'hC3, 8'hC3, 8'hC3, 8'hD4, 8'hD4, 8'hD4};

        rst  = 1'b0;
        rst8 = 1'b0;
        c32 = 32'h0000_0400; sw32 = 5'd10; mode32 = 2'b00; load32 = 1'b0;
        c4  = 32'hD4C3_B2A1; sw4  = 2'd0;  mode4  = 2'b00; load4  = 1'b0;
        c5  = 20'h54321;     sw5  = 3'd0;  mode5  = 2'b00; load5  = 1'b0;
        c8  = 32'h7654_3210; sw8  = 3'd0;  mode8  = 2'b01; load8  = 1'b0;
        #1;
        rst  = 1'b1;
        rst8 = 1'b1;

        // Reset dominates the clock.
        tick(2);
        chk("rst_o32", 32'(o32), 32'd0);
        chk("rst_cur32", 32'(cur32), 32'd0);
        chk("rst_o4", 32'(o4), 32'd0);
        chk("rst_wrap4", 32'(wrap4), 32'd0);

        // Manual select latency: cur_sel after 1 edge, o after 2.
        rst = 1'b0;
        tick();
        chk("man_cur_1edge", 32'(cur32), 32'd10);
        chk("man_o_1edge", 32'(o32), 32'd0);
        tick();
        chk("man_o_2edge", 32'(o32), 32'd1);

        for (int i = 0; i < 6; i++) begin
            sw32 = vt[i].sw;
            c32  = vt[i].c;
            tick();
            chk("tbl_cur", 32'(cur32), 32'(vt[i].exp_sel));
            tick();
            chk("tbl_o", 32'(o32), 32'(vt[i].exp_o));
        end

        // Data to output with the channel fixed: one edge.
        c32 = 32'h0;
        tick();
        chk("c_to_o_latency", 32'(o32), 32'd0);

        // Scan wrap on N=4, DWELL=3.
        chk("scan_pre_o", 32'(o4), 32'hA1);
        mode4 = 2'b01;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("scan_cur", 32'(cur4), 32'(seq4[i]));
            chk("scan_o", 32'(o4), 32'(o4e[i]));
            chk("scan_wrap", 32'(wrap4), (i == 12) ? 32'd1 : 32'd0);
        end

        // Load mid-dwell at cur_sel=1, dcnt=1.
        tick(3);
        chk("ld_pre_cur_a", 32'(cur4), 32'd1);
        tick();
        chk("ld_pre_cur_b", 32'(cur4), 32'd1);
        load4 = 1'b1;
        sw4   = 2'd3;
        tick();
        load4 = 1'b0;
        sw4   = 2'd0;
        chk("ld_cur", 32'(cur4), 32'd3);
        chk("ld_no_wrap", 32'(wrap4), 32'd0);
        tick();
        chk("ld_hold1", 32'(cur4), 32'd3);
        chk("ld_o", 32'(o4), 32'hD4);
        tick();
        chk("ld_hold2", 32'(cur4), 32'd3);
        tick();
        chk("ld_wrap_cur", 32'(cur4), 32'd0);
        chk("ld_wrap", 32'(wrap4), 32'd1);

        // Hold freeze at cur_sel=2 with o showing channel 2.
        tick(7);
        chk("hold_pre_cur", 32'(cur4), 32'd2);
        chk("hold_pre_o", 32'(o4), 32'hC3);
        mode4 = 2'b10;
        c4    = ~c4;
        sw4   = 2'd1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode4 = 2'b11;
            tick();
            chk("hold_cur", 32'(cur4), 32'd2);
            chk("hold_o", 32'(o4), 32'hC3);
            chk("hold_wrap", 32'(wrap4), 32'd0);
        end
        mode4 = 2'b01;
        tick();
        chk("unhold_cur1", 32'(cur4), 32'd2);
        chk("unhold_o1", 32'(o4), 32'h3C);
        tick();
        chk("unhold_cur2", 32'(cur4), 32'd2);
        tick();
        chk("unhold_cur3", 32'(cur4), 32'd2);
        tick();
        chk("unhold_adv", 32'(cur4), 32'd3);

        // Out-of-range select on N=5.
        sw5 = 3'd2;
        tick();
        chk("oor_cur2", 32'(cur5), 32'd2);
        sw5 = 3'd6;
        tick();
        chk("oor_keep_a", 32'(cur5), 32'd2);
        chk("oor_o", 32'(o5), 32'd3);
        tick();
        chk("oor_keep_b", 32'(cur5), 32'd2);
        sw5 = 3'd4;
        tick();
        chk("oor_last", 32'(cur5), 32'd4);
        sw5 = 3'd5;
        tick();
        chk("oor_eqN", 32'(cur5), 32'd4);
        mode5 = 2'b01;
        tick(2);
        chk("s5_pre_wrap", 32'(cur5), 32'd4);
        tick();
        chk("s5_wrap_cur", 32'(cur5), 32'd0);
        chk("s5_wrap", 32'(wrap5), 32'd1);
        tick();
        load5 = 1'b1;
        sw5   = 3'd7;
        tick();
        load5 = 1'b0;
        chk("s5_oor_load_cur", 32'(cur5), 32'd0);
        tick();
        chk("s5_oor_load_dwell", 32'(cur5), 32'd0);
        tick();
        chk("s5_oor_load_adv", 32'(cur5), 32'd1);

        // Load alongside a mode change: only honoured when landing in SCAN.
        mode5 = 2'b10;
        load5 = 1'b1;
        sw5   = 3'd3;
        tick();
        chk("ld_into_hold", 32'(cur5), 32'd1);
        mode5 = 2'b01;
        tick();
        load5 = 1'b0;
        chk("ld_into_scan", 32'(cur5), 32'd3);
        tick();
        chk("ld_into_scan_dw", 32'(cur5), 32'd3);
        chk("ld_into_scan_o", 32'(o5), 32'd4);
        tick();
        chk("ld_into_scan_adv", 32'(cur5), 32'd4);

        // DWELL=1 scan on N=8 and asynchronous reset mid-scan.
        rst8 = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk("d1_cur", 32'(cur8), 32'((t - 1) % 8));
            chk("d1_wrap", 32'(wrap8), (t > 1 && (t - 1) % 8 == 0) ? 32'd1 : 32'd0);
            e = (t < 2) ? 0 : (t - 2) % 8;
            chk("d1_o", 32'(o8), 32'(e));
        end
        tick(5);
        chk("d1_pre_rst_cur", 32'(cur8), 32'd5);
        chk("d1_pre_rst_o", 32'(o8), 32'd4);
        #2;
        rst8 = 1'b1;
        #1;
        chk("async_o", 32'(o8), 32'd0);
        chk("async_cur", 32'(cur8), 32'd0);
        chk("async_wrap", 32'(wrap8), 32'd0);
        tick();
        rst8 = 1'b0;
        tick();
        chk("post_rst_entry", 32'(cur8), 32'd0);
        tick();
        chk("post_rst_adv", 32'(cur8), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
